count_update_checker: RTL and testbench

Synthesizable checker at the receiving end of the 4-bit free-running counter interface. It observes `count` and the counter's reset and flags updates that arrive early, arrive late, or carry the wrong value. Each violation is queued as a timestamped record and drained through a valid/ready port. It sits beside the counter in the timing-violation-predictor datapath and supplies labelled violation events to downstream logging and feature extraction.

---
 rtl/timing_mon_pkg.sv | 20 ++
 rtl/viol_fifo.sv | 66 ++++++
 rtl/count_update_checker.sv | 148 ++++++++++++++
 tb/tb_count_update_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_mon_pkg.sv
// Shared definitions for the count update checker: violation encodings,
// checker FSM states and the violation counter saturation value.
package timing_mon_pkg;

  typedef enum logic [1:0] {
    ViolNone  = 2'b00,
    ViolEarly = 2'b01,
    ViolLate  = 2'b10,
    ViolValue = 2'b11
  } viol_type_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StTrack = 2'b10
  } state_e;

  localparam logic [7:0] ViolCountMax = 8'd255;

endpackage

// File: rtl/viol_fifo.sv
// Synchronous FIFO holding violation records.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   push_i, wdata_i write request and data (ignored when full unless popping)
//   pop_i           read request (ignored when empty)
//   rdata_o         head record, driven from the storage flops
//   full_o, empty_o occupancy flags
// Depth must be a power of two and at least 2.
module viol_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AddrW-1:0]] = wdata_i;
      wptr_d = wptr_q + (AddrW + 1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/count_update_checker.sv
// Checks the update timing and value of an observed free-running counter.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   dut_rst, count_in       observed reset and value of the monitored counter
//   viol_valid/viol_ready   record handshake; head fields viol_type, viol_stamp,
//                           viol_obs, viol_exp
//   viol_count              saturating total of detected violations
//   overflow                sticky: a record was dropped on a full queue
module count_update_checker
  import timing_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned PERIOD     = 1,
  parameter int unsigned STAMP_W    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dut_rst,
  input  logic [CNT_W-1:0]   count_in,
  output logic               viol_valid,
  input  logic               viol_ready,
  output logic [1:0]         viol_type,
  output logic [STAMP_W-1:0] viol_stamp,
  output logic [CNT_W-1:0]   viol_obs,
  output logic [CNT_W-1:0]   viol_exp,
  output logic [7:0]         viol_count,
  output logic               overflow
);

  localparam int unsigned RecW = 2 + STAMP_W + 2 * CNT_W;
  // gap never exceeds PERIOD-1; cyc needs one more bit to reach PERIOD.
  localparam int unsigned GapW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [GapW:0] PeriodC = (GapW + 1)'(PERIOD);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rec_vld_q, rec_vld_d;
  logic [RecW-1:0]    rec_q, rec_d;
  logic               ovf_q, ovf_d;

  logic [GapW:0]      cyc;
  logic [CNT_W-1:0]   exp_val;
  logic               det;
  viol_type_e         det_type;
  logic               fifo_full, fifo_empty, pop;
  logic [RecW-1:0]    head;

  assign exp_val = last_q + CNT_W'(1);
  assign cyc     = {1'b0, gap_q} + (GapW + 1)'(1);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gap_d    = gap_q;
    det      = 1'b0;
    det_type = ViolNone;
    unique case (state_q)
      StIdle: begin
        if (dut_rst) state_d = StArmed;
      end
      StArmed: begin
        if (!dut_rst) begin
          last_d  = count_in;
          gap_d   = '0;
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (dut_rst) begin
          state_d = StArmed;
        end else if (count_in != last_q) begin
          if (count_in != exp_val) begin
            det      = 1'b1;
            det_type = ViolValue;
          end else if (cyc < PeriodC) begin
            det      = 1'b1;
            det_type = ViolEarly;
          end
          last_d = count_in;
          gap_d  = '0;
        end else if (cyc == PeriodC) begin
          det      = 1'b1;
          det_type = ViolLate;
          gap_d    = '0;
        end else begin
          gap_d = cyc[GapW-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = viol_valid & viol_ready;

  always_comb begin
    stamp_d   = stamp_q + STAMP_W'(1);
    cnt_d     = (det && (cnt_q != ViolCountMax)) ? cnt_q + 8'd1 : cnt_q;
    rec_vld_d = det;
    rec_d     = {det_type, stamp_q, count_in, exp_val};
    ovf_d     = ovf_q | (rec_vld_q & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= '0;
      gap_q     <= '0;
      stamp_q   <= '0;
      cnt_q     <= '0;
      rec_vld_q <= 1'b0;
      rec_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      stamp_q   <= stamp_d;
      cnt_q     <= cnt_d;
      rec_vld_q <= rec_vld_d;
      rec_q     <= rec_d;
      ovf_q     <= ovf_d;
    end
  end

  viol_fifo #(
    .Width(RecW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (rec_vld_q),
    .wdata_i(rec_q),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign viol_valid = ~fifo_empty;
  assign {viol_type, viol_stamp, viol_obs, viol_exp} = head;
  assign viol_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_count_update_checker.sv
module tb_count_update_checker;

  localparam int RecW = 2 + 16 + 2 * 4;

  logic        clk = 1'b0;
  logic        rst, dut_rst, viol_ready, viol_ready2;
  logic [3:0]  count_in;
  logic        viol_valid, viol_valid2, overflow, overflow2;
  logic [1:0]  viol_type, viol_type2;
  logic [15:0] viol_stamp, viol_stamp2;
  logic [3:0]  viol_obs, viol_obs2, viol_exp, viol_exp2;
  logic [7:0]  viol_count, viol_count2;

  count_update_checker #(.CNT_W(4), .PERIOD(1), .STAMP_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .count_in(count_in),
    .viol_valid(viol_valid), .viol_ready(viol_ready), .viol_type(viol_type),
    .viol_stamp(viol_stamp), .viol_obs(viol_obs), .viol_exp(viol_exp),
    .viol_count(viol_count), .overflow(overflow)
  );

  count_update_checker #(.CNT_W(4), .PERIOD(2), .STAMP_W(16), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .count_in(count_in),
    .viol_valid(viol_valid2), .viol_ready(viol_ready2), .viol_type(viol_type2),
    .viol_stamp(viol_stamp2), .viol_obs(viol_obs2), .viol_exp(viol_exp2),
    .viol_count(viol_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  // Cycle number of the sample about to be taken, counted from reset release.
  logic [15:0] tb_stamp;
  always @(posedge clk) begin
    if (rst) tb_stamp <= '0;
    else     tb_stamp <= tb_stamp + 16'd1;
  end

  logic [RecW-1:0] exp_q[$];
  logic [RecW-1:0] exp_rec;
  logic [RecW-1:0] got1;
  int errors  = 0;
  int checks  = 0;
  int exp_cnt = 0;

  assign got1 = {viol_type, viol_stamp, viol_obs, viol_exp};

  function automatic logic [RecW-1:0] mk(input logic [1:0] t, input logic [3:0] o,
                                         input logic [3:0] e);
    return {t, tb_stamp, o, e};
  endfunction

  task automatic step(input logic [3:0] c, input logic dr);
    count_in = c;
    dut_rst  = dr;
    @(posedge clk);
    #1;
  endtask

  // Record a violation that the next sample must produce and that must be queued.
  task automatic expect_viol(input logic [1:0] t, input logic [3:0] o, input logic [3:0] e);
    exp_q.push_back(mk(t, o, e));
    exp_cnt++;
  endtask

  // Scoreboard: every accepted head record must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && viol_valid && viol_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL record_unexpected: got %h, required no record", got1);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got1 !== exp_rec) begin
          errors++;
          $display("FAIL record_match: got %h, required %h", got1, exp_rec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dut_rst = 1'b0; count_in = '0; viol_ready = 1'b1; viol_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(viol_valid), 32'd0);
    chk("reset_count", 32'(viol_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_type", 32'(viol_type), 32'd0);
    chk("reset_stamp", 32'(viol_stamp), 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    int seen = 0;
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      step(4'(i % 16), 1'b0);
      if (viol_valid !== 1'b0) seen++;
    end
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    chk("clean_valid_seen", 32'(seen), 32'd0);
    chk("clean_valid", 32'(viol_valid), 32'd0);
    chk("clean_count", 32'(viol_count), 32'd0);
  endtask

  task automatic test_skip();
    step(4'd4, 1'b1);
    step(4'd4, 1'b0);
    step(4'd5, 1'b0);
    expect_viol(2'b11, 4'd7, 4'd6);
    step(4'd7, 1'b0);
    chk("skip_count", 32'(viol_count), 32'(exp_cnt));
    chk("skip_valid_early", 32'(viol_valid), 32'd0);
    step(4'd8, 1'b0);
    chk("skip_valid_late", 32'(viol_valid), 32'd1);
    step(4'd8, 1'b1);
    step(4'd8, 1'b1);
  endtask

  task automatic test_stall();
    step(4'd2, 1'b1);
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_viol(2'b10, 4'd3, 4'd4);
      step(4'd3, 1'b0);
    end
    step(4'd3, 1'b1);
    chk("stall_count", 32'(viol_count), 32'(exp_cnt));
    repeat (3) step(4'd3, 1'b1);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_backpressure();
    logic [3:0] prev;
    rst = 1'b1;
    step(4'd0, 1'b1);
    rst = 1'b0;
    exp_cnt = 0;
    viol_ready = 1'b0;
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    prev = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) begin
        expect_viol(2'b11, 4'(2 * i), prev + 4'd1);
      end else begin
        exp_cnt++;
      end
      step(4'(2 * i), 1'b0);
      prev = 4'(2 * i);
    end
    step(4'd12, 1'b1);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_count", 32'(viol_count), 32'd6);
    chk("bp_head", got1, exp_q[0]);
    step(4'd12, 1'b1);
    chk("bp_head_stable", got1, exp_q[0]);
    viol_ready = 1'b1;
    repeat (6) step(4'd12, 1'b1);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_valid_after", 32'(viol_valid), 32'd0);
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);
  endtask

  task automatic test_period2();
    logic [15:0] s2;
    rst = 1'b1;
    step(4'd3, 1'b1);
    rst = 1'b0;
    exp_cnt = 0;
    step(4'd3, 1'b1);
    step(4'd3, 1'b0);
    // The PERIOD=1 instance sees this hold as a late update.
    expect_viol(2'b10, 4'd3, 4'd4);
    step(4'd3, 1'b0);
    step(4'd4, 1'b0);
    s2 = tb_stamp;
    step(4'd5, 1'b0);
    chk("p2_count", 32'(viol_count2), 32'd1);
    step(4'd5, 1'b1);
    chk("p2_valid", 32'(viol_valid2), 32'd1);
    chk("p2_record", {viol_type2, viol_stamp2, viol_obs2, viol_exp2},
        {2'b01, s2, 4'd5, 4'd5});
    step(4'd5, 1'b1);
    chk("p2_p1_count", 32'(viol_count), 32'(exp_cnt));
  endtask

  task automatic test_mid_track_reset();
    step(4'd8, 1'b1);
    step(4'd8, 1'b0);
    step(4'd9, 1'b0);
    step(4'd9, 1'b1);
    step(4'd0, 1'b0);
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    step(4'd2, 1'b1);
    step(4'd2, 1'b1);
    chk("mid_count", 32'(viol_count), 32'(exp_cnt));
    chk("mid_valid", 32'(viol_valid), 32'd0);
    chk("mid_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_rst_flush();
    viol_ready = 1'b0;
    step(4'd0, 1'b1);
    step(4'd0, 1'b0);
    step(4'd2, 1'b0);
    step(4'd4, 1'b0);
    step(4'd4, 1'b1);
    step(4'd4, 1'b1);
    chk("flush_pre_valid", 32'(viol_valid), 32'd1);
    chk("flush_pre_count", 32'(viol_count), 32'(exp_cnt + 2));
    rst = 1'b1;
    step(4'd4, 1'b1);
    chk("flush_valid", 32'(viol_valid), 32'd0);
    chk("flush_count", 32'(viol_count), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    viol_ready = 1'b1;
    step(4'd4, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish within 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean();
    test_skip();
    test_stall();
    test_backpressure();
    test_period2();
    test_mid_track_reset();
    test_rst_flush();
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
